// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester byte streams and UART TX FIFO write port bundle
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 2
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic               uart_tx_ready;
  logic               uart_wen;
  logic [7:0]         uart_wdata;
  logic [GW-1:0]      grant_id;
  logic               busy;

  modport master (
    input  req_valid, req_data, req_last, uart_tx_ready,
    output req_ready, uart_wen, uart_wdata, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, req_last, uart_tx_ready,
    input  req_ready, uart_wen, uart_wdata, grant_id, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, message-granular arbiter sharing one UART TX FIFO
module uart_tx_arbiter #(
  parameter int N_REQ        = 2,
  parameter int MAX_BURST    = 16,
  parameter int HOLD_TIMEOUT = 64
) (
  input  logic              hb_clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, XFER, GAP, REL} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [7:0]    burst_q, burst_d;
  logic [7:0]    idle_q, idle_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          wen_q, wen_d;

  logic [GW-1:0] rr_pick;
  logic          rr_found;
  logic          cur_valid;
  logic          cur_last;
  logic [7:0]    cur_data;
  logic          accept;
  int            idx;

  // Search starts one past the last served requester; wrap is done by subtraction so any N_REQ works.
  always_comb begin
    rr_pick  = last_q;
    rr_found = 1'b0;
    idx      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!rr_found && bus.req_valid[idx]) begin
        rr_found = 1'b1;
        rr_pick  = GW'(idx);
      end
    end
  end

  assign cur_valid = bus.req_valid[grant_q];
  assign cur_last  = bus.req_last[grant_q];
  assign cur_data  = bus.req_data[{grant_q, 3'b000} +: 8];
  assign accept    = (state_q == XFER) && cur_valid && bus.uart_tx_ready;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    burst_d       = burst_q;
    idle_d        = idle_q;
    wen_d         = 1'b0;
    wdata_d       = wdata_q;
    bus.req_ready = '0;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          grant_d = rr_pick;
          burst_d = '0;
          idle_d  = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        bus.req_ready[grant_q] = bus.uart_tx_ready;
        if (accept) begin
          wen_d   = 1'b1;
          wdata_d = cur_data;
          burst_d = burst_q + 8'd1;
          idle_d  = '0;
          state_d = (cur_last || burst_q == 8'(MAX_BURST - 1)) ? REL : GAP;
        end else if (!cur_valid) begin
          // Only a silent requester counts toward the timeout; FIFO back-pressure does not.
          idle_d = idle_q + 8'd1;
          if (idle_q == 8'(HOLD_TIMEOUT - 1)) state_d = REL;
        end
      end
      GAP: state_d = XFER;
      REL: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hb_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(N_REQ - 1);
      burst_q <= '0;
      idle_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      idle_q  <= idle_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.uart_wen   = wen_q;
  assign bus.uart_wdata = wdata_q;
  assign bus.grant_id   = grant_q;
  assign bus.busy       = (state_q != IDLE);
endmodule
